// File: rtl/cover_pkg.sv
// Shared types and helpers for the cover counter bank: dump FSM states, saturating math, index width.
// Pure declarations, no logic; no latency or backpressure of its own.
package cover_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } dump_state_e;

    // Wide enough that any counter (COUNT_W <= 63) plus one hit never overflows the helpers.
    localparam int SAT_W = 64;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] v,
                                                 input logic [SAT_W-1:0] inc,
                                                 input logic [SAT_W-1:0] maxv);
        logic [SAT_W:0] sum;
        sum = {1'b0, v} + {1'b0, inc};
        return (sum > {1'b0, maxv}) ? maxv : sum[SAT_W-1:0];
    endfunction

    function automatic logic [SAT_W-1:0] sat_sub(input logic [SAT_W-1:0] v,
                                                 input logic [SAT_W-1:0] dec);
        return (dec > v) ? '0 : v - dec;
    endfunction

endpackage

// File: rtl/cover_point_counter.sv
// One cover channel: match comparator, saturating hit counter, clear-by-subtract on dump accept.
// Counter updates every cycle; hit_o is combinational; no backpressure.
module cover_point_counter
    import cover_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] MATCH_VAL = '0,
    parameter int                COUNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               en_i,
    input  logic [DATA_W-1:0]  dat_i,
    input  logic               clr_i,
    input  logic [COUNT_W-1:0] clr_val_i,
    output logic               hit_o,
    output logic [COUNT_W-1:0] count_o
);

    localparam logic [SAT_W-1:0] MAXV = (SAT_W'(1) << COUNT_W) - SAT_W'(1);

    logic [COUNT_W-1:0] cnt_q;
    logic [COUNT_W-1:0] cnt_d;
    logic [SAT_W-1:0]   base;

    assign hit_o   = en_i && (dat_i == MATCH_VAL);
    assign count_o = cnt_q;

    // Subtract the dumped snapshot first so hits since the snapshot (and this cycle's) survive.
    always_comb begin
        base = SAT_W'(cnt_q);
        if (clr_i) begin
            base = sat_sub(base, SAT_W'(clr_val_i));
        end
        cnt_d = COUNT_W'(sat_add(base, SAT_W'(hit_o), MAXV));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cover_counter_bank.sv
// N-channel cover counter bank with streamed dump; optional SVA under COVER_COUNTER_ASSERT_EN.
// dump_req -> first beat 2 cycles later, one bubble between beats; beats hold while out_ready is low.
module cover_counter_bank
    import cover_pkg::*;
#(
    parameter int                N_CH          = 2,
    parameter int                DATA_W        = 8,
    parameter logic [DATA_W-1:0] MATCH_VAL     = '0,
    parameter int                COUNT_W       = 16,
    parameter int                CLEAR_ON_READ = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         en,
    input  logic [N_CH*DATA_W-1:0]       a,
    output logic [N_CH-1:0]              hit,
    input  logic                         dump_req,
    output logic                         dump_busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [idx_width(N_CH)-1:0]   out_idx,
    output logic [COUNT_W-1:0]           out_count,
    output logic                         out_last
);

    localparam int               IDX_W    = idx_width(N_CH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

    dump_state_e        state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               valid_q;
    logic               last_q;
    logic [COUNT_W-1:0] snap_q;
    logic [COUNT_W-1:0] cnt_w [N_CH];
    logic               accept;

    assign accept = valid_q && out_ready;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic clr;
        assign clr = (CLEAR_ON_READ != 0) && accept && (idx_q == IDX_W'(g));

        cover_point_counter #(
            .DATA_W    (DATA_W),
            .MATCH_VAL (MATCH_VAL),
            .COUNT_W   (COUNT_W)
        ) u_cnt (
            .clock     (clock),
            .reset     (reset),
            .en_i      (en),
            .dat_i     (a[g*DATA_W +: DATA_W]),
            .clr_i     (clr),
            .clr_val_i (snap_q),
            .hit_o     (hit[g]),
            .count_o   (cnt_w[g])
        );

`ifdef COVER_COUNTER_ASSERT_EN
        cp_hit: cover property (@(posedge clock) disable iff (reset) hit[g]);
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            snap_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dump_req) begin
                        idx_q   <= '0;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    snap_q  <= cnt_w[idx_q];
                    last_q  <= (idx_q == LAST_IDX);
                    valid_q <= 1'b1;
                    state_q <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        if (last_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= ST_LOAD;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dump_busy = (state_q != ST_IDLE);
    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign out_count = snap_q;
    assign out_last  = last_q;

`ifdef COVER_COUNTER_ASSERT_EN
    ap_hold: assert property (@(posedge clock) disable iff (reset)
        out_valid && !out_ready |=> $stable(out_idx) && $stable(out_count) && $stable(out_last));
`else
    // Without SVA support only the counting and dump logic above is built.
`endif

endmodule

// File: tb/tb_cover_counter_bank.sv
module tb_cover_counter_bank;

    localparam int N_CH   = 2;
    localparam int DATA_W = 8;
    localparam int CW     = 4;
    localparam int MAXC   = 15;

    logic                   clock     = 1'b0;
    logic                   reset     = 1'b1;
    logic                   en        = 1'b0;
    logic                   dump_req  = 1'b0;
    logic                   out_ready = 1'b0;
    logic [N_CH*DATA_W-1:0] a         = '0;
    logic [N_CH-1:0]        hit;
    logic                   dump_busy;
    logic                   out_valid;
    logic                   out_last;
    logic [0:0]             out_idx;
    logic [CW-1:0]          out_count;

    int checks = 0;
    int fails  = 0;

    cover_counter_bank #(
        .N_CH          (N_CH),
        .DATA_W        (DATA_W),
        .MATCH_VAL     (8'h00),
        .COUNT_W       (CW),
        .CLEAR_ON_READ (1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .a         (a),
        .hit       (hit),
        .dump_req  (dump_req),
        .dump_busy (dump_busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_count (out_count),
        .out_last  (out_last)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-channel hit totals with saturation, and the dump beat schedule.
    int cyc = 0;
    int m_cnt [N_CH];
    bit m_active = 1'b0;
    int m_idx = 0;
    int m_due = 0;
    int m_snap = 0;
    bit exp_v;
    int h;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
            m_active = 1'b0;
        end else begin
            exp_v = m_active && (cyc >= m_due);
            chk("mon_valid", out_valid, exp_v);
            chk("mon_busy", dump_busy, m_active);
            if (m_active && cyc == m_due - 1) m_snap = m_cnt[m_idx];
            if (exp_v) begin
                chk("mon_idx", out_idx, m_idx);
                chk("mon_count", out_count, m_snap);
                chk("mon_last", out_last, m_idx == N_CH - 1);
            end
            for (int i = 0; i < N_CH; i++) begin
                h = (en && a[i*DATA_W +: DATA_W] == 8'h00) ? 1 : 0;
                chk("mon_hit", hit[i], h);
                if (exp_v && out_ready && i == m_idx) m_cnt[i] = m_cnt[i] - m_snap + h;
                else m_cnt[i] = m_cnt[i] + h;
                if (m_cnt[i] > MAXC) m_cnt[i] = MAXC;
            end
            if (exp_v && out_ready) begin
                if (m_idx == N_CH - 1) m_active = 1'b0;
                else begin
                    m_idx++;
                    m_due = cyc + 2;
                end
            end else if (!m_active && dump_req) begin
                m_active = 1'b1;
                m_idx    = 0;
                m_due    = cyc + 2;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic expect_beat(input int ei, input int ec, input int el);
        int k;
        k = 0;
        @(negedge clock);
        while (!out_valid && k < 8) begin
            @(negedge clock);
            k++;
        end
        chk("beat_valid", out_valid, 1);
        chk("beat_idx", out_idx, ei);
        chk("beat_count", out_count, ec);
        chk("beat_last", out_last, el);
    endtask

    task automatic finish_dump();
        @(negedge clock);
        chk("end_busy", dump_busy, 0);
        chk("end_valid", out_valid, 0);
        step();
    endtask

    task automatic dump2(input int e0, input int e1);
        out_ready = 1'b1;
        dump_req  = 1'b1;
        step();
        dump_req  = 1'b0;
        expect_beat(0, e0, 0);
        step();
        expect_beat(1, e1, 1);
        step();
        finish_dump();
    endtask

    typedef struct {
        logic                   v_en;
        logic [N_CH*DATA_W-1:0] v_a;
        logic [N_CH-1:0]        v_hit;
    } vec_t;

    vec_t vecs [7];
    int   beats;
    int   c0;
    int   c1;

    initial begin
        vecs[0] = '{1'b1, 16'h0000, 2'b11};
        vecs[1] = '{1'b1, 16'h1100, 2'b01};
        vecs[2] = '{1'b1, 16'h0011, 2'b10};
        vecs[3] = '{1'b0, 16'h0000, 2'b00};
        vecs[4] = '{1'b1, 16'h8001, 2'b00};
        vecs[5] = '{1'b1, 16'h0100, 2'b01};
        vecs[6] = '{1'b0, 16'h1100, 2'b00};

        // Reset state
        repeat (3) step();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", dump_busy, 0);
        chk("rst_last", out_last, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_count", out_count, 0);
        step();

        // Five hits on ch0, none on ch1, with exact first-beat latency
        en = 1'b1;
        a  = 16'h1100;
        repeat (5) step();
        en = 1'b0;
        out_ready = 1'b1;
        dump_req  = 1'b1;
        step();
        dump_req  = 1'b0;
        @(negedge clock);
        chk("t1_lat_valid", out_valid, 0);
        chk("t1_lat_busy", dump_busy, 1);
        expect_beat(0, 5, 0);
        step();
        expect_beat(1, 0, 1);
        step();
        finish_dump();

        // Saturation at 15 without wrap, then cleared by the dump
        do_reset();
        en = 1'b1;
        a  = 16'h1100;
        repeat (20) step();
        en = 1'b0;
        dump2(15, 0);
        dump2(0, 0);

        // Stalled beat holds its snapshot; hits since snapshot survive the clear
        do_reset();
        en = 1'b1;
        a  = 16'h1100;
        out_ready = 1'b0;
        repeat (2) step();
        en = 1'b0;
        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
        expect_beat(0, 2, 0);
        step();
        en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            chk("t3_hold_count", out_count, 2);
            chk("t3_hold_valid", out_valid, 1);
            step();
        end
        out_ready = 1'b1;
        step();
        en = 1'b0;
        expect_beat(1, 0, 1);
        step();
        finish_dump();
        dump2(11, 0);

        // dump_req during SEND is ignored
        do_reset();
        en = 1'b1;
        a  = 16'h1100;
        repeat (3) step();
        en = 1'b0;
        out_ready = 1'b0;
        dump_req  = 1'b1;
        step();
        dump_req  = 1'b0;
        expect_beat(0, 3, 0);
        step();
        dump_req = 1'b1;
        step();
        step();
        dump_req  = 1'b0;
        out_ready = 1'b1;
        beats = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (out_valid && out_ready) beats++;
            step();
        end
        chk("t4_beats", beats, 2);
        @(negedge clock);
        chk("t4_busy", dump_busy, 0);
        step();

        // Reset in the middle of a dump
        do_reset();
        en = 1'b1;
        a  = 16'h0000;
        repeat (3) step();
        en = 1'b0;
        out_ready = 1'b1;
        dump_req  = 1'b1;
        step();
        dump_req  = 1'b0;
        expect_beat(0, 3, 0);
        step();
        out_ready = 1'b0;
        expect_beat(1, 3, 1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("t5_valid", out_valid, 0);
        chk("t5_busy", dump_busy, 0);
        chk("t5_idx", out_idx, 0);
        chk("t5_count", out_count, 0);
        chk("t5_last", out_last, 0);
        step();
        dump2(0, 0);

        // Enable low masks matches
        do_reset();
        en = 1'b0;
        a  = 16'h0000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            chk("t6_hit", hit, 0);
            step();
        end
        dump2(0, 0);

        // Table of single-cycle hit vectors, totals checked through a dump
        do_reset();
        c0 = 0;
        c1 = 0;
        for (int k = 0; k < 7; k++) begin
            en = vecs[k].v_en;
            a  = vecs[k].v_a;
            @(negedge clock);
            chk("tbl_hit", hit, vecs[k].v_hit);
            c0 += int'(vecs[k].v_hit[0]);
            c1 += int'(vecs[k].v_hit[1]);
            step();
        end
        en = 1'b0;
        dump2(c0, c1);

        // Random traffic against the reference model
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            reset     = ($urandom_range(0, 199) == 0);
            en        = ($urandom_range(0, 3) != 0);
            dump_req  = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            for (int i = 0; i < N_CH; i++) begin
                a[i*DATA_W +: DATA_W] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            end
            step();
        end
        reset     = 1'b0;
        en        = 1'b0;
        dump_req  = 1'b0;
        out_ready = 1'b1;
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
